// File: rtl/uart_alu_pkg.sv
// Shared opcode encodings and FSM state type for the UART command ALU.
package uart_alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

endpackage

// File: rtl/uart_alu_if_alu_core.sv
// Combinational ALU: unsigned operands, truncated result, unknown opcodes give 0.
module alu_core
  import uart_alu_pkg::*;
#(
  parameter int N_BIT = 8,
  parameter int N_OP  = 6
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic [N_OP-1:0]  op,
  output logic [N_BIT-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      // Oversized arithmetic shifts saturate to the sign explicitly.
      OP_SRA:  result = (32'(b) >= N_BIT) ? {N_BIT{a[N_BIT-1]}}
                                          : $unsigned($signed(a) >>> b);
      OP_SRL:  result = a >> b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_if.sv
// Frame engine: pops {A, B, OP} from the RX FIFO, evaluates, pushes the result to TX.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_alu_if
  import uart_alu_pkg::*;
#(
  parameter int N_BIT          = 8,
  parameter int N_OP           = 6,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TO_BIT         = 17
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [N_BIT-1:0] w_data,
  output logic             wr_uart,
  output logic             busy,
  output logic             frame_abort
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [N_BIT-1:0]  r_opA;
  logic [N_BIT-1:0]  r_opB;
  logic [N_OP-1:0]   r_opCode;
  logic [N_BIT-1:0]  r_result;
  logic [N_BIT-1:0]  w_aluResult;
  logic              w_pop;
  logic              w_push;
  logic              w_abort;
  logic              w_timeout;

  alu_core #(.N_BIT(N_BIT), .N_OP(N_OP)) u_alu (
    .a      (r_opA),
    .b      (r_opB),
    .op     (r_opCode),
    .result (w_aluResult)
  );

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (!rx_empty) begin
          w_pop       = 1'b1;
          w_stateNext = WAIT_B;
        end
      end
      WAIT_B: begin
        if (!rx_empty) begin
          w_pop       = 1'b1;
          w_stateNext = WAIT_OP;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_stateNext = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (!rx_empty) begin
          w_pop       = 1'b1;
          w_stateNext = EXEC;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_stateNext = WAIT_A;
        end
      end
      EXEC: w_stateNext = SEND;
      SEND: begin
        if (!tx_full) begin
          w_push      = 1'b1;
          w_stateNext = WAIT_A;
        end
      end
      default: w_stateNext = WAIT_A;
    endcase
  end

  // Strobes are masked while reset is held so no FIFO is touched mid-reset.
  assign rd_uart     = w_pop && RESET;
  assign wr_uart     = w_push && RESET;
  assign frame_abort = w_abort && RESET;
  assign busy        = (r_state != WAIT_A);
  assign w_data      = r_result;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= WAIT_A;
      r_opA    <= '0;
      r_opB    <= '0;
      r_opCode <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_pop) begin
        case (r_state)
          WAIT_A:  r_opA    <= r_data;
          WAIT_B:  r_opB    <= r_data;
          WAIT_OP: r_opCode <= r_data[N_OP-1:0];
          default: ;
        endcase
      end
      if (r_state == EXEC) begin
        r_result <= w_aluResult;
      end
      if (w_abort) begin
        r_opA <= '0;
        r_opB <= '0;
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  logic [TO_BIT-1:0] r_toCnt;
  logic              w_waiting;

  assign w_waiting = (r_state == WAIT_B) || (r_state == WAIT_OP);
  assign w_timeout = w_waiting && rx_empty &&
                     (r_toCnt == TO_BIT'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes of a frame; any pop restarts the window.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_toCnt <= '0;
    end else if (!w_waiting || w_pop || w_abort) begin
      r_toCnt <= '0;
    end else if (rx_empty) begin
      r_toCnt <= r_toCnt + TO_BIT'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if with a queue-backed RX FIFO model.
module tb_uart_alu_if;

  logic       CLK;
  logic       RESET;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       busy;
  logic       frame_abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxQ[$];
  int         cycleNo;
  int         popCnt;
  int         pushCnt;
  int         abortCnt;
  int         lastPopCycle;
  int         abortCycle;
  int         popWhenEmpty;
  int         pushCycles[$];
  logic [7:0] pushData[$];
  logic [7:0] dataSeen;
  logic       pushSeen;

  uart_alu_if #(
    .N_BIT(8), .N_OP(6), .TIMEOUT_CYCLES(16), .TO_BIT(5)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .tx_full     (tx_full),
    .w_data      (w_data),
    .wr_uart     (wr_uart),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveRx();
    rx_empty = (rxQ.size() == 0);
    r_data   = (rxQ.size() == 0) ? 8'h00 : rxQ[0];
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxQ.push_back(b);
    driveRx();
  endtask

  task automatic clearLogs();
    popCnt       = 0;
    pushCnt      = 0;
    abortCnt     = 0;
    popWhenEmpty = 0;
    lastPopCycle = -1;
    abortCycle   = -1;
    pushCycles.delete();
    pushData.delete();
  endtask

  // One clock: sample outputs at the falling edge, then update the FIFO model after the rise.
  task automatic cycle();
    logic popSeen;
    @(negedge CLK);
    popSeen  = rd_uart;
    pushSeen = wr_uart;
    dataSeen = w_data;
    if (rd_uart) begin
      popCnt++;
      lastPopCycle = cycleNo;
      if (rx_empty) popWhenEmpty++;
    end
    if (wr_uart) begin
      pushCnt++;
      pushCycles.push_back(cycleNo);
      pushData.push_back(w_data);
    end
    if (frame_abort) begin
      abortCnt++;
      abortCycle = cycleNo;
    end
    cycleNo++;
    @(posedge CLK);
    #1;
    if (popSeen && rxQ.size() > 0) void'(rxQ.pop_front());
    driveRx();
  endtask

  task automatic waitPops(input int n, input string tag);
    int budget = 200;
    while (popCnt < n && budget > 0) begin
      cycle();
      budget--;
    end
    if (popCnt < n) checkOutput({tag, "_popTimeout"}, popCnt, n);
  endtask

  task automatic waitPushes(input int n, input string tag);
    int budget = 200;
    while (pushCnt < n && budget > 0) begin
      cycle();
      budget--;
    end
    if (pushCnt < n) checkOutput({tag, "_pushTimeout"}, pushCnt, n);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] expected);
    clearLogs();
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(op);
    waitPushes(1, tag);
    repeat (3) cycle();
    checkOutput({tag, "_data"}, (pushData.size() > 0) ? pushData[0] : 8'hxx, expected);
    checkOutput({tag, "_pushes"}, pushCnt, 1);
    checkOutput({tag, "_pops"}, popCnt, 3);
    checkOutput({tag, "_latency"},
                (pushCycles.size() > 0) ? pushCycles[0] - lastPopCycle : -1, 2);
    checkOutput({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    cycleNo  = 0;
    RESET    = 1'b0;
    tx_full  = 1'b0;
    rx_empty = 1'b0;
    r_data   = 8'h5A;
    clearLogs();
    #12;
    checkOutput("reset_rd", rd_uart, 1'b0);
    checkOutput("reset_wr", wr_uart, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_wdata", w_data, 8'h00);
    checkOutput("reset_abort", frame_abort, 1'b0);
    driveRx();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (2) cycle();
    checkOutput("idle_pops", popCnt, 0);

    runFrame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    runFrame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    runFrame("sra", 8'h80, 8'h01, 8'h03, 8'hC0);
    runFrame("srl", 8'h80, 8'h01, 8'h02, 8'h40);
    runFrame("illegal", 8'h0F, 8'hF0, 8'h3F, 8'h00);
    runFrame("andUpper", 8'hCC, 8'hAA, 8'hE4, 8'h88);
    runFrame("or", 8'hC0, 8'h0C, 8'h25, 8'hCC);
    runFrame("xor", 8'hFF, 8'h0F, 8'h26, 8'hF0);
    runFrame("nor", 8'h10, 8'h01, 8'h27, 8'hEE);
    runFrame("addWrap", 8'hFF, 8'h02, 8'h20, 8'h01);
    runFrame("sraBig", 8'h80, 8'h08, 8'h03, 8'hFF);
    runFrame("sraBigPos", 8'h40, 8'hFF, 8'h03, 8'h00);
    runFrame("srlBig", 8'h80, 8'h09, 8'h02, 8'h00);

    begin : txFullHold
      logic [7:0] heldData;
      int         dataMoved;
      clearLogs();
      tx_full = 1'b1;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h20);
      waitPops(3, "txFull");
      cycle();
      dataMoved = 0;
      cycle();
      heldData = dataSeen;
      repeat (9) begin
        cycle();
        if (dataSeen !== heldData) dataMoved++;
      end
      checkOutput("txFull_noPush", pushCnt, 0);
      checkOutput("txFull_stable", dataMoved, 0);
      checkOutput("txFull_held", heldData, 8'h33);
      checkOutput("txFull_busy", busy, 1'b1);
      tx_full = 1'b0;
      cycle();
      checkOutput("txFull_release", pushSeen, 1'b1);
      checkOutput("txFull_data", dataSeen, 8'h33);
    end

    clearLogs();
    applyStimulus(8'h07);
    applyStimulus(8'h02);
    applyStimulus(8'h22);
    applyStimulus(8'h09);
    applyStimulus(8'h06);
    applyStimulus(8'h24);
    waitPushes(2, "b2b");
    repeat (3) cycle();
    checkOutput("b2b_pops", popCnt, 6);
    checkOutput("b2b_pushes", pushCnt, 2);
    checkOutput("b2b_data0", (pushData.size() > 0) ? pushData[0] : 8'hxx, 8'h05);
    checkOutput("b2b_data1", (pushData.size() > 1) ? pushData[1] : 8'hxx, 8'h00);
    checkOutput("b2b_gap",
                (pushCycles.size() > 1) ? pushCycles[1] - pushCycles[0] : -1, 5);
    checkOutput("b2b_popEmpty", popWhenEmpty, 0);

    clearLogs();
    applyStimulus(8'h77);
    waitPops(1, "midReset");
    checkOutput("midReset_busy", busy, 1'b1);
    RESET = 1'b0;
    #2;
    checkOutput("midReset_busyLow", busy, 1'b0);
    repeat (2) cycle();
    RESET = 1'b1;
    runFrame("afterReset", 8'h01, 8'h01, 8'h20, 8'h02);

`ifdef FRAME_TIMEOUT_EN
    begin : frameTimeout
      int popAt;
      clearLogs();
      applyStimulus(8'h44);
      waitPops(1, "timeout");
      popAt = lastPopCycle;
      repeat (20) cycle();
      checkOutput("timeout_abortCnt", abortCnt, 1);
      checkOutput("timeout_abortCycle", abortCycle - popAt, 16);
      checkOutput("timeout_busy", busy, 1'b0);
      checkOutput("timeout_noPush", pushCnt, 0);
    end
    runFrame("afterTimeout", 8'h30, 8'h03, 8'h22, 8'h2D);
`else
    clearLogs();
    applyStimulus(8'h44);
    waitPops(1, "stall");
    repeat (40) cycle();
    checkOutput("stall_noAbort", abortCnt, 0);
    checkOutput("stall_busy", busy, 1'b1);
    applyStimulus(8'h04);
    applyStimulus(8'h20);
    waitPushes(1, "stall");
    checkOutput("stall_data", (pushData.size() > 0) ? pushData[0] : 8'hxx, 8'h48);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
